// File: rtl/sen_lut_arbiter.sv
// Round-robin arbiter in front of the shared sine lookup memory (senFuncMem).
// One lane is granted per cycle. The memory is read combinationally through
// rom_a, and the sample is captured into a response register together with
// the owning lane index. Addresses at or beyond AMOUNT never reach the
// memory: they are answered with a zero sample and the oob flag set.
//
// Handshakes:
//   request side  - req[i] is held (with a stable addr slice) until the lane
//                   sees gnt[i]=1 at a rising edge; that edge accepts it.
//   response side - resp_valid/resp_ready: a response leaves on any edge
//                   where both are 1. While resp_valid=1 and resp_ready=0
//                   (stall) the response is frozen and no grant is issued.
module sen_lut_arbiter #(
  parameter int WIDTH  = 24,
  parameter int AMOUNT = 302,
  parameter int LANES  = 4,
  parameter int AW     = 9,
  parameter int LW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      req,
  input  logic [LANES*AW-1:0]   addr,
  output logic [LANES-1:0]      gnt,
  output logic [AW-1:0]         rom_a,
  input  logic [WIDTH-1:0]      rom_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LW-1:0]         resp_lane,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_oob
);

  // One extra bit so AMOUNT == 2**AW still compares correctly.
  localparam logic [AW:0]   AMOUNT_W = AMOUNT[AW:0];
  localparam logic [LW-1:0] LAST     = LW'(LANES - 1);

  logic [LW-1:0] ptr;
  logic          stall;
  logic          gnt_any;
  logic [LW-1:0] gnt_idx;
  logic [LW-1:0] ptr_next;
  logic [AW-1:0] sel_addr;
  logic          sel_oob;

  assign stall = resp_valid & ~resp_ready;

  // Lane reached after stepping 'off' positions from 'base', wrapping mod LANES.
  function automatic logic [LW-1:0] lane_at(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= LANES) s = s - LANES;
    return LW'(s);
  endfunction

  // Pick the first requesting lane starting at ptr; nothing while stalled or in reset.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rst && !stall) begin
      for (int j = 0; j < LANES; j++) begin
        if (!gnt_any && req[lane_at(ptr, j)]) begin
          gnt_any = 1'b1;
          gnt_idx = lane_at(ptr, j);
        end
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

  // Route the granted lane's address to the memory, masking out-of-range ones.
  always_comb begin
    sel_addr = addr[int'(gnt_idx)*AW +: AW];
    sel_oob  = ({1'b0, sel_addr} >= AMOUNT_W);
    rom_a    = (gnt_any && !sel_oob) ? sel_addr : '0;
    ptr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  // Response register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_lane  <= '0;
      resp_data  <= '0;
      resp_oob   <= 1'b0;
      ptr        <= '0;
    end else if (gnt_any) begin
      resp_valid <= 1'b1;
      resp_lane  <= gnt_idx;
      resp_oob   <= sel_oob;
      resp_data  <= sel_oob ? '0 : rom_rd;
      ptr        <= ptr_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
